qpu_exu_wbck_arbt: RTL and testbench
====================================

Name: qpu_exu_wbck_arbt

Overview:
- Arbitrates the shared writeback ports of the EXU general-purpose register file between three requesters: ALU, long-pipe (LSU/memory) and MCU readback (FMR result).
- Bit [RFIDX_REAL_W-1] of the destination index selects the bank:
  - 0: classical bank, driven through the cwbck_* port.
  - 1: quantum bank, driven through the qcwbck_* port.
- Each bank has an independent round-robin arbiter, so one classical write and one quantum write can retire in the same cycle.

Parameters:
- XLEN, 32, data width.
- RFIDX_REAL_W, 6, destination index width; MSB is the bank select.
- NREQ, 3, number of requesters. Fixed at 3; index 0 = ALU, 1 = long-pipe, 2 = MCU.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester accept; a write transfers when valid & ready.
- req_idx  in  NREQ*RFIDX_REAL_W  packed destination indices; requester r occupies slice [r*W +: W].
- req_data  in  NREQ*XLEN  packed write data.
- cwbck_dest_wen  out  1  classical bank write enable.
- cwbck_dest_idx  out  RFIDX_REAL_W  classical bank write index.
- cwbck_dest_data  out  XLEN  classical bank write data.
- qcwbck_dest_wen  out  1  quantum bank write enable.
- qcwbck_dest_idx  out  RFIDX_REAL_W  quantum bank write index.
- qcwbck_dest_data  out  XLEN  quantum bank write data.
- wbck_busy  out  1  any request pending or write in flight; used for flush/retire.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - Both round-robin pointers reset to 0 (ALU highest priority).
  - cwbck_dest_wen = 0, qcwbck_dest_wen = 0.
  - idx/data outputs reset to 0.
  - req_ready = 0 while rst_n is low.
  - wbck_busy = 0.
- Bank classification per requester: bank_q[r] = req_idx[r][MSB].
  - The classical arbiter sees valid & ~bank_q.
  - The quantum arbiter sees valid & bank_q.
- Arbitration, per bank:
  - Round-robin with a 2-bit pointer ptr in {0,1,2}.
  - Search order: ptr, ptr+1, ptr+2, each mod 3.
  - The first requesting requester wins.
  - On a grant, ptr <= winner+1 mod 3.
  - With no grant, ptr holds.
- Handshake:
  - req_ready[r] = 1 only in the cycle requester r is granted by its bank's arbiter.
  - A requester must hold valid, idx and data stable until ready.
  - req_ready is never asserted without req_valid.
- Classical index 0 (idx = 0, bank 0):
  - The request is still granted and handshaked, and the pointer advances.
  - cwbck_dest_wen is forced to 0 for that write (x0 is constant zero).
- Quantum indices below QUBIT_NUM, or equal to all-ones:
  - These are read-only in the regfile, but the arbiter does not filter them.
  - Write-protection is the regfile's responsibility.
- Simultaneous events:
  - One classical grant and one quantum grant from different requesters are both accepted in the same cycle.
  - A requester can only be in one bank per cycle, so it can never receive two grants.
- Latency:
  - Without the optional feature, outputs are combinational from the grant: 0-cycle latency.
  - In that case the cwbck_/qcwbck_ outputs reflect the current-cycle winner.
- Starvation bound: a continuously valid requester is granted within 3 cycles in its bank.
- wbck_busy = |req_valid, OR'd with the pipeline-register valids when the optional feature is compiled in.
- Reset mid-operation: pending requests are dropped without a handshake, pointers return to 0 and outputs deassert asynchronously.

Optional Feature:
- Macro: QPU_WBCK_ARBT_OUTREG_EN.
- Defined:
  - The cwbck_* and qcwbck_* outputs come from a registered stage, giving 1-cycle latency (grant in cycle N, wen asserted in cycle N+1).
  - The stage always accepts because the regfile never stalls, so req_ready timing is unchanged.
  - The x0 suppression is applied before the register.
- Undefined: combinational outputs as above.
- Both builds must produce an identical grant order.

Test Plan:
- Reset:
  - Stimulus: hold rst_n = 0 with all req_valid = 1.
  - Response: req_ready = 000, both wen = 0, wbck_busy = 0.
  - Release reset: the first classical grant goes to the ALU.
- Classical round-robin:
  - Stimulus: all three requesters valid continuously to classical x5, x6 and x7 with data 0xA, 0xB, 0xC.
  - Response: grants in order 0,1,2,0,1,2…
  - cwbck_dest_idx sequence 5,6,7 with the matching data; wen = 1 every cycle.
- Dual-bank concurrency:
  - Stimulus: ALU writes classical x3 = 0x11; MCU writes quantum idx 0x2D (q-bank reg 13) = 0x22, in the same cycle.
  - Response: both ready bits = 1 in that cycle.
  - cwbck: idx 3, data 0x11. qcwbck: idx 0x2D, data 0x22. Both wen = 1.
- x0 drop:
  - Stimulus: long-pipe writes classical idx 0 with 0xFFFF.
  - Response: req_ready[1] = 1 and cwbck_dest_wen = 0.
  - Next classical grant priority starts at requester 2.
- Fairness:
  - Stimulus: ALU continuously valid; MCU becomes valid in cycle 4 (classical bank).
  - Response: MCU granted by cycle 6 at the latest, and holds valid until then.
- OUTREG build:
  - Stimulus: repeat the round-robin scenario with QPU_WBCK_ARBT_OUTREG_EN defined.
  - Response: the same idx/data sequence delayed by exactly 1 cycle.
  - wbck_busy stays high one cycle after the last req_valid falls.

Source files
------------

// File: rtl/qpu_exu_wbck_arbt_if.sv
// Writeback request/response bundle between the EXU requesters (ALU, long-pipe, MCU)
// and the writeback arbiter; master = requester side, slave = arbiter.
interface qpu_exu_wbck_arbt_if #(
  parameter int XLEN         = 32,
  parameter int RFIDX_REAL_W = 6,
  parameter int NREQ         = 3
);
  logic [NREQ-1:0]                   req_valid;
  logic [NREQ-1:0]                   req_ready;
  logic [NREQ-1:0][RFIDX_REAL_W-1:0] req_idx;
  logic [NREQ-1:0][XLEN-1:0]         req_data;

  logic                    cwbck_dest_wen;
  logic [RFIDX_REAL_W-1:0] cwbck_dest_idx;
  logic [XLEN-1:0]         cwbck_dest_data;
  logic                    qcwbck_dest_wen;
  logic [RFIDX_REAL_W-1:0] qcwbck_dest_idx;
  logic [XLEN-1:0]         qcwbck_dest_data;
  logic                    wbck_busy;

  modport master (
    output req_valid, req_idx, req_data,
    input  req_ready,
    input  cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data,
    input  qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data,
    input  wbck_busy
  );

  modport slave (
    input  req_valid, req_idx, req_data,
    output req_ready,
    output cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data,
    output qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data,
    output wbck_busy
  );
endinterface

// File: rtl/qpu_exu_wbck_arbt.sv
// Per-bank round-robin writeback arbiter (classical / quantum regfile banks).
// Optional macro QPU_WBCK_ARBT_OUTREG_EN registers the bank outputs for 1-cycle latency.

module qpu_exu_wbck_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output logic       vld_o
);
  logic [1:0] ptr_q, ptr_d, cand;
  logic       found;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Walk ptr, ptr+1, ptr+2 (mod 3); first requester wins and the pointer moves past it.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    cand  = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        ptr_d       = nxt(cand);
        found       = 1'b1;
      end
      cand = nxt(cand);
    end
  end

  assign vld_o = found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
endmodule

module qpu_exu_wbck_arbt #(
  parameter int XLEN         = 32,
  parameter int RFIDX_REAL_W = 6,
  parameter int NREQ         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qpu_exu_wbck_arbt_if.slave    wb
);
  localparam int NBANK = 2;

  logic [NREQ-1:0]                    req_qbank;
  logic [NBANK-1:0][NREQ-1:0]         bank_req;
  logic [NBANK-1:0][NREQ-1:0]         bank_gnt;
  logic [NBANK-1:0]                   bank_vld;
  logic [NBANK-1:0]                   wen_d;
  logic [NBANK-1:0][RFIDX_REAL_W-1:0] idx_d;
  logic [NBANK-1:0][XLEN-1:0]         data_d;

  always_comb begin
    req_qbank = '0;
    for (int r = 0; r < NREQ; r++) req_qbank[r] = wb.req_idx[r][RFIDX_REAL_W-1];
  end

  // Gating with rst_n keeps ready and the comb outputs quiet while reset is held.
  assign bank_req[0] = wb.req_valid & ~req_qbank & {NREQ{rst_n}};
  assign bank_req[1] = wb.req_valid &  req_qbank & {NREQ{rst_n}};

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    qpu_exu_wbck_rr u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b]),
      .vld_o (bank_vld[b])
    );
  end

  always_comb begin
    idx_d  = '0;
    data_d = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (bank_gnt[b][r]) begin
          idx_d[b]  = wb.req_idx[r];
          data_d[b] = wb.req_data[r];
        end
      end
    end
  end

  // x0 is hardwired zero: the handshake completes but the write is dropped.
  assign wen_d[0] = bank_vld[0] & (idx_d[0] != '0);
  assign wen_d[1] = bank_vld[1];

  assign wb.req_ready = bank_gnt[0] | bank_gnt[1];

`ifdef QPU_WBCK_ARBT_OUTREG_EN
  logic [NBANK-1:0]                   vld_q, wen_q;
  logic [NBANK-1:0][RFIDX_REAL_W-1:0] idx_q;
  logic [NBANK-1:0][XLEN-1:0]         data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      wen_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= bank_vld;
      wen_q  <= wen_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign wb.cwbck_dest_wen   = wen_q[0];
  assign wb.cwbck_dest_idx   = idx_q[0];
  assign wb.cwbck_dest_data  = data_q[0];
  assign wb.qcwbck_dest_wen  = wen_q[1];
  assign wb.qcwbck_dest_idx  = idx_q[1];
  assign wb.qcwbck_dest_data = data_q[1];
  // A granted write still in the output stage (x0 included) counts as in flight.
  assign wb.wbck_busy        = rst_n & ((|wb.req_valid) | (|vld_q));
`else
  assign wb.cwbck_dest_wen   = wen_d[0];
  assign wb.cwbck_dest_idx   = idx_d[0];
  assign wb.cwbck_dest_data  = data_d[0];
  assign wb.qcwbck_dest_wen  = wen_d[1];
  assign wb.qcwbck_dest_idx  = idx_d[1];
  assign wb.qcwbck_dest_data = data_d[1];
  assign wb.wbck_busy        = rst_n & (|wb.req_valid);
`endif
endmodule

// File: tb/tb_qpu_exu_wbck_arbt.sv
// Scoreboard bench for qpu_exu_wbck_arbt: a rule-level model predicts grants and writes,
// a negedge monitor compares DUT outputs against the queued predictions.
module tb_qpu_exu_wbck_arbt;
  localparam int XLEN = 32;
  localparam int W    = 6;
  localparam int N    = 3;
`ifdef QPU_WBCK_ARBT_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpu_exu_wbck_arbt_if #(.XLEN(XLEN), .RFIDX_REAL_W(W), .NREQ(N)) wb ();

  qpu_exu_wbck_arbt #(.XLEN(XLEN), .RFIDX_REAL_W(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  typedef struct { int cyc; logic [W-1:0] idx; logic [XLEN-1:0] data; } wr_t;
  typedef struct { logic [N-1:0] rdy; logic busy; } cy_t;

  wr_t cq[$];
  wr_t qq[$];
  cy_t eq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic            v  [N];
  logic [W-1:0]    ri [N];
  logic [XLEN-1:0] rd [N];
  int cptr = 0, qptr = 0;
  bit prev_gnt = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Round-robin rule: search ptr, ptr+1, ptr+2 (mod 3); first active requester wins.
  function automatic int pick(logic [N-1:0] m, int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      wb.req_valid[r] = v[r];
      wb.req_idx[r]   = ri[r];
      wb.req_data[r]  = rd[r];
    end
  endtask

  // Called at posedge+1: apply requests, predict this cycle, advance to next posedge+1.
  task automatic cycle();
    logic [N-1:0] cm, qm, rdy;
    int cw, qw;
    bit anyv;
    drive();
    cyc++;
    anyv = 1'b0;
    for (int r = 0; r < N; r++) begin
      cm[r] = v[r] & ~ri[r][W-1];
      qm[r] = v[r] &  ri[r][W-1];
      anyv  = anyv | v[r];
    end
    cw = pick(cm, cptr);
    qw = pick(qm, qptr);
    rdy = '0;
    if (cw >= 0) begin
      rdy[cw] = 1'b1;
      cptr = (cw + 1) % N;
      if (ri[cw] != 0) cq.push_back(wr_t'{cyc + LAT, ri[cw], rd[cw]});
    end
    if (qw >= 0) begin
      rdy[qw] = 1'b1;
      qptr = (qw + 1) % N;
      qq.push_back(wr_t'{cyc + LAT, ri[qw], rd[qw]});
    end
    eq.push_back(cy_t'{rdy, anyv | (LAT == 1 && prev_gnt)});
    prev_gnt = (cw >= 0) || (qw >= 0);
    if (cw >= 0) v[cw] = 1'b0;
    if (qw >= 0) v[qw] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, logic [W-1:0] idx, logic [XLEN-1:0] data);
    v[r]  = 1'b1;
    ri[r] = idx;
    rd[r] = data;
  endtask

  // Monitor: per-cycle ready/busy plus bank writes matched in order with their due cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cy_t e;
        wr_t w;
        if (eq.size() == 0) fail_now("cycle_queue_empty");
        else begin
          e = eq.pop_front();
          chk("req_ready", 64'(wb.req_ready), 64'(e.rdy));
          chk("wbck_busy", 64'(wb.wbck_busy), 64'(e.busy));
        end
        if (wb.cwbck_dest_wen) begin
          if (cq.size() == 0) fail_now("cwbck_unexpected_wen");
          else begin
            w = cq.pop_front();
            chk("cwbck_cycle", 64'(cyc), 64'(w.cyc));
            chk("cwbck_idx",   64'(wb.cwbck_dest_idx),  64'(w.idx));
            chk("cwbck_data",  64'(wb.cwbck_dest_data), 64'(w.data));
          end
        end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
          fail_now("cwbck_missing_write");
          void'(cq.pop_front());
        end
        if (wb.qcwbck_dest_wen) begin
          if (qq.size() == 0) fail_now("qcwbck_unexpected_wen");
          else begin
            w = qq.pop_front();
            chk("qcwbck_cycle", 64'(cyc), 64'(w.cyc));
            chk("qcwbck_idx",   64'(wb.qcwbck_dest_idx),  64'(w.idx));
            chk("qcwbck_data",  64'(wb.qcwbck_dest_data), 64'(w.data));
          end
        end else if (qq.size() > 0 && qq[0].cyc <= cyc) begin
          fail_now("qcwbck_missing_write");
          void'(qq.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ready"}, 64'(wb.req_ready), 64'd0);
    chk({tag, "_cwen"},  64'(wb.cwbck_dest_wen), 64'd0);
    chk({tag, "_qwen"},  64'(wb.qcwbck_dest_wen), 64'd0);
    chk({tag, "_busy"},  64'(wb.wbck_busy), 64'd0);
    chk({tag, "_cidx"},  64'(wb.cwbck_dest_idx), 64'd0);
    chk({tag, "_cdata"}, 64'(wb.cwbck_dest_data), 64'd0);
    chk({tag, "_qidx"},  64'(wb.qcwbck_dest_idx), 64'd0);
    chk({tag, "_qdata"}, 64'(wb.qcwbck_dest_data), 64'd0);
  endtask

  initial begin
    // Reset held with every requester valid.
    for (int r = 0; r < N; r++) set_req(r, 6'(5 + r), 32'(32'hA + r));
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Classical round-robin to x5/x6/x7, continuously valid.
    repeat (9) begin
      for (int r = 0; r < N; r++) if (!v[r]) set_req(r, 6'(5 + r), 32'(32'hA + r));
      cycle();
    end
    repeat (4) cycle();

    // Dual-bank concurrency.
    set_req(0, 6'd3, 32'h11);
    set_req(2, 6'h2D, 32'h22);
    cycle();
    cycle();

    // x0 write from long-pipe, then contention to observe pointer position.
    set_req(1, 6'd0, 32'hFFFF);
    cycle();
    for (int r = 0; r < N; r++) set_req(r, 6'(8 + r), 32'(32'h100 + r));
    repeat (4) cycle();

    // Fairness: ALU always valid, MCU joins at cycle 4.
    for (int k = 0; k < 8; k++) begin
      if (!v[0]) set_req(0, 6'd1, 32'(32'h200 + k));
      if (k == 4) set_req(2, 6'd2, 32'h300);
      cycle();
    end
    repeat (4) cycle();

    // Randomized traffic across both banks, including x0 and q-bank reserved indices.
    repeat (400) begin
      for (int r = 0; r < N; r++) begin
        if (!v[r] && $urandom_range(1, 0) == 1) begin
          if ($urandom_range(7, 0) == 0) set_req(r, 6'd0, $urandom);
          else set_req(r, 6'($urandom), $urandom);
        end
      end
      cycle();
    end

    // Asynchronous reset in the middle of traffic.
    for (int r = 0; r < N; r++) set_req(r, 6'(20 + r), 32'(32'h400 + r));
    drive();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cq.delete();
    qq.delete();
    eq.delete();
    cptr = 0;
    qptr = 0;
    prev_gnt = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (4) cycle();

    // Drain and confirm nothing predicted was left unwritten.
    for (int r = 0; r < N; r++) v[r] = 1'b0;
    repeat (3) cycle();
    chk("cq_drained", 64'(cq.size()), 64'd0);
    chk("qq_drained", 64'(qq.size()), 64'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
